// File: rtl/interp_span_sched.sv
// interp_span_sched
// Span sequencer for the perspective-correct attribute interpolator.
// It takes one span descriptor at a time and steps it pixel by pixel. It
// issues one interpolator request per pixel, with at most MAX_OUT requests
// outstanding. Each returning result is tagged with its pixel x and an
// end-of-span flag.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   span_valid / span_ready     descriptor handshake
//   span_x0, span_len           first pixel x, pixel count (0 allowed)
//   span_v, span_q              start v/w and 1/w
//   span_dv, span_dq            per-pixel gradients
//   ip_in_valid / ip_in_ready   request handshake to the interpolator
//   ip_init_v, ip_init_q        request base values
//   ip_dv_dx, ip_dq_dx          request gradients
//   ip_out_valid / ip_out_ready result handshake from the interpolator
//   ip_interp_v                 interpolated result
//   pix_valid / pix_ready       tagged result handshake to the fragment stage
//   pix_x, pix_v, pix_last      pixel x, result value, final-pixel flag
//   busy                        sequencer not idle
module interp_span_sched #(
  parameter int WIDTH   = 32,
  parameter int XW      = 12,
  parameter int LENW    = 12,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             span_valid,
  output logic             span_ready,
  input  logic [XW-1:0]    span_x0,
  input  logic [LENW-1:0]  span_len,
  input  logic [WIDTH-1:0] span_v,
  input  logic [WIDTH-1:0] span_q,
  input  logic [WIDTH-1:0] span_dv,
  input  logic [WIDTH-1:0] span_dq,
  output logic             ip_in_valid,
  input  logic             ip_in_ready,
  output logic [WIDTH-1:0] ip_init_v,
  output logic [WIDTH-1:0] ip_init_q,
  output logic [WIDTH-1:0] ip_dv_dx,
  output logic [WIDTH-1:0] ip_dq_dx,
  input  logic             ip_out_valid,
  output logic             ip_out_ready,
  input  logic [WIDTH-1:0] ip_interp_v,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [XW-1:0]    pix_x,
  output logic [WIDTH-1:0] pix_v,
  output logic             pix_last,
  output logic             busy
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_MAX  = CW'(MAX_OUT);
  localparam logic [PW-1:0]   PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]   PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]   PTR_LAST = PW'(MAX_OUT - 1);
  localparam logic [LENW-1:0] LEN_ZERO = {LENW{1'b0}};
  localparam logic [LENW-1:0] LEN_ONE  = {{(LENW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0]   X_ZERO   = {XW{1'b0}};
  localparam logic [XW-1:0]   X_ONE    = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] W_ZERO  = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_v_q, acc_v_d;
  logic [WIDTH-1:0] acc_q_q, acc_q_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [XW-1:0]    x_q, x_d;
  logic [LENW-1:0]  rem_q, rem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [XW-1:0]    tag_x_q    [MAX_OUT];
  logic [XW-1:0]    tag_x_d    [MAX_OUT];
  logic             tag_last_q [MAX_OUT];
  logic             tag_last_d [MAX_OUT];

  logic fifo_nonempty;
  logic credit_ok;
  logic issue_fire;
  logic pix_fire;
  logic span_fire;

  // Circular pointer advance over MAX_OUT entries (depth need not be a power of two).
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  // Handshake qualifiers. The FIFO fill always equals the outstanding count,
  // so the count doubles as the FIFO occupancy.
  always_comb begin
    fifo_nonempty = (cnt_q != CNT_ZERO);
    credit_ok     = (cnt_q < CNT_MAX);
    issue_fire    = (state_q == S_ISSUE) && credit_ok && ip_in_ready;
    pix_fire      = ip_out_valid && fifo_nonempty && pix_ready;
    span_fire     = span_valid && (state_q == S_IDLE);
  end

  // Outstanding-request counter: an issue and a return in the same cycle cancel.
  always_comb begin
    cnt_d = cnt_q;
    case ({issue_fire, pix_fire})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Tag FIFO: push {x, last} on issue, pop on the downstream handshake.
  always_comb begin
    tag_x_d    = tag_x_q;
    tag_last_d = tag_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (issue_fire) begin
      tag_x_d[wr_ptr_q]    = x_q;
      tag_last_d[wr_ptr_q] = (rem_q == LEN_ONE);
      wr_ptr_d             = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pix_fire) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Sequencer next state. The accumulators start one gradient behind because
  // the interpolator adds the gradient to the base it receives.
  always_comb begin
    state_d = state_q;
    acc_v_d = acc_v_q;
    acc_q_d = acc_q_q;
    dv_d    = dv_q;
    dq_d    = dq_q;
    x_d     = x_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (span_fire && (span_len != LEN_ZERO)) begin
          acc_v_d = span_v - span_dv;
          acc_q_d = span_q - span_dq;
          dv_d    = span_dv;
          dq_d    = span_dq;
          x_d     = span_x0;
          rem_d   = span_len;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (issue_fire) begin
          acc_v_d = acc_v_q + dv_q;
          acc_q_d = acc_q_q + dq_q;
          x_d     = x_q + X_ONE;
          rem_d   = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (cnt_d == CNT_ZERO) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      acc_v_q  <= W_ZERO;
      acc_q_q  <= W_ZERO;
      dv_q     <= W_ZERO;
      dq_q     <= W_ZERO;
      x_q      <= X_ZERO;
      rem_q    <= LEN_ZERO;
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_v_q  <= acc_v_d;
      acc_q_q  <= acc_q_d;
      dv_q     <= dv_d;
      dq_q     <= dq_d;
      x_q      <= x_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Tag FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        tag_x_q[i]    <= X_ZERO;
        tag_last_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        tag_x_q[i]    <= tag_x_d[i];
        tag_last_q[i] <= tag_last_d[i];
      end
    end
  end

  // Outputs. The return path is deliberately combinational (zero latency);
  // everything else comes straight from registers.
  always_comb begin
    span_ready   = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    ip_in_valid  = (state_q == S_ISSUE) && credit_ok;
    ip_init_v    = acc_v_q;
    ip_init_q    = acc_q_q;
    ip_dv_dx     = dv_q;
    ip_dq_dx     = dq_q;
    pix_valid    = ip_out_valid && fifo_nonempty;
    ip_out_ready = pix_ready && fifo_nonempty;
    pix_x        = tag_x_q[rd_ptr_q];
    pix_last     = tag_last_q[rd_ptr_q] && fifo_nonempty;
    pix_v        = ip_interp_v;
  end

endmodule

// File: tb/tb_interp_span_sched.sv
// Testbench for interp_span_sched: scoreboard of expected requests and tagged
// pixels pushed when a span is accepted, popped as the DUT hands them over.
module tb_interp_span_sched;

  localparam int WIDTH   = 32;
  localparam int XW      = 12;
  localparam int LENW    = 12;
  localparam int MAX_OUT = 4;
  localparam int BIG     = 1000000;

  logic             clk;
  logic             rst_n;
  logic             span_valid;
  logic             span_ready;
  logic [XW-1:0]    span_x0;
  logic [LENW-1:0]  span_len;
  logic [WIDTH-1:0] span_v, span_q, span_dv, span_dq;
  logic             ip_in_valid;
  logic             ip_in_ready;
  logic [WIDTH-1:0] ip_init_v, ip_init_q, ip_dv_dx, ip_dq_dx;
  logic             ip_out_valid;
  logic             ip_out_ready;
  logic [WIDTH-1:0] ip_interp_v;
  logic             pix_valid;
  logic             pix_ready;
  logic [XW-1:0]    pix_x;
  logic [WIDTH-1:0] pix_v;
  logic             pix_last;
  logic             busy;

  interp_span_sched #(.WIDTH(WIDTH), .XW(XW), .LENW(LENW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .span_valid(span_valid), .span_ready(span_ready),
    .span_x0(span_x0), .span_len(span_len),
    .span_v(span_v), .span_q(span_q), .span_dv(span_dv), .span_dq(span_dq),
    .ip_in_valid(ip_in_valid), .ip_in_ready(ip_in_ready),
    .ip_init_v(ip_init_v), .ip_init_q(ip_init_q), .ip_dv_dx(ip_dv_dx), .ip_dq_dx(ip_dq_dx),
    .ip_out_valid(ip_out_valid), .ip_out_ready(ip_out_ready), .ip_interp_v(ip_interp_v),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_v(pix_v), .pix_last(pix_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Span request staged by the main sequence, driven by the cycle loop.
  logic             span_go = 1'b0;
  logic [XW-1:0]    req_x0;
  logic [LENW-1:0]  req_len;
  logic [WIDTH-1:0] req_v, req_q, req_dv, req_dq;

  // Environment controls.
  int   ret_allow   = BIG;   // results the interpolator model may still return
  logic pix_stall   = 1'b0;
  logic in_rdy_rand = 1'b0;

  // Scoreboard queues.
  logic [WIDTH-1:0] exp_iv[$], exp_iq[$], exp_dv[$], exp_dq[$];
  logic [XW-1:0]    exp_x[$];
  logic [WIDTH-1:0] exp_pv[$];
  logic             exp_last[$];

  // Interpolator model: results in order, each ready two cycles after issue.
  logic [WIDTH-1:0] pend_v[$];
  int               pend_t[$];

  int   cyc = 0;
  int   issued = 0;
  int   pix_seen = 0;
  logic saw_in_valid = 1'b0;
  logic stalled_prev = 1'b0;
  logic [WIDTH-1:0] prev_iv, prev_iq, prev_dv, prev_dq;

  // Cycle loop: drive at the falling edge, then inspect the handshakes that
  // the next rising edge will complete.
  initial begin
    span_valid   = 1'b0;
    span_x0      = '0;
    span_len     = '0;
    span_v       = '0;
    span_q       = '0;
    span_dv      = '0;
    span_dq      = '0;
    ip_in_ready  = 1'b1;
    ip_out_valid = 1'b0;
    ip_interp_v  = '0;
    pix_ready    = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      span_valid  = span_go;
      span_x0     = req_x0;
      span_len    = req_len;
      span_v      = req_v;
      span_q      = req_q;
      span_dv     = req_dv;
      span_dq     = req_dq;
      ip_in_ready = in_rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_ready   = !pix_stall;
      ip_out_valid = (pend_v.size() > 0) && (ret_allow > 0) && (pend_t[0] <= cyc);
      ip_interp_v  = ip_out_valid ? pend_v[0] : 32'h0;
      #1;
      if (ip_in_valid) saw_in_valid = 1'b1;
      if (stalled_prev) begin
        check_eq("stall_valid", ip_in_valid, 1'b1);
        check_eq("stall_init_v", ip_init_v, prev_iv);
        check_eq("stall_init_q", ip_init_q, prev_iq);
        check_eq("stall_dv", ip_dv_dx, prev_dv);
        check_eq("stall_dq", ip_dq_dx, prev_dq);
      end
      stalled_prev = ip_in_valid && !ip_in_ready;
      prev_iv = ip_init_v;
      prev_iq = ip_init_q;
      prev_dv = ip_dv_dx;
      prev_dq = ip_dq_dx;
      if (pix_stall) check_eq("bp_out_ready", ip_out_ready, 1'b0);
      if (ip_out_valid || pix_valid) check_eq("pix_valid", pix_valid, ip_out_valid);
      if (span_valid && span_ready) begin
        for (int k = 0; k < int'(span_len); k++) begin
          logic [WIDTH-1:0] kk;
          logic [XW-1:0]    xk;
          kk = WIDTH'(k);
          xk = span_x0 + XW'(k);
          exp_iv.push_back(span_v + kk * span_dv - span_dv);
          exp_iq.push_back(span_q + kk * span_dq - span_dq);
          exp_dv.push_back(span_dv);
          exp_dq.push_back(span_dq);
          exp_x.push_back(xk);
          exp_pv.push_back(span_v + kk * span_dv);
          exp_last.push_back(k == int'(span_len) - 1);
        end
        span_go = 1'b0;
      end
      if (ip_in_valid && ip_in_ready) begin
        check_eq("credit", pend_v.size() < MAX_OUT, 1'b1);
        if (exp_iv.size() == 0) begin
          check_eq("extra_issue", 1'b1, 1'b0);
        end else begin
          check_eq("init_v", ip_init_v, exp_iv.pop_front());
          check_eq("init_q", ip_init_q, exp_iq.pop_front());
          check_eq("dv_dx", ip_dv_dx, exp_dv.pop_front());
          check_eq("dq_dx", ip_dq_dx, exp_dq.pop_front());
        end
        pend_v.push_back(ip_init_v + ip_dv_dx);
        pend_t.push_back(cyc + 2);
        issued++;
      end
      if (pix_valid && pix_ready) begin
        if (exp_x.size() == 0) begin
          check_eq("extra_pix", 1'b1, 1'b0);
        end else begin
          check_eq("pix_x", pix_x, exp_x.pop_front());
          check_eq("pix_v", pix_v, exp_pv.pop_front());
          check_eq("pix_last", pix_last, exp_last.pop_front());
        end
        if (pend_v.size() > 0) begin
          void'(pend_v.pop_front());
          void'(pend_t.pop_front());
        end
        ret_allow--;
        pix_seen++;
      end
    end
  end

  task automatic send_span(input logic [XW-1:0] x0, input logic [LENW-1:0] len,
                           input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] q,
                           input logic [WIDTH-1:0] dv, input logic [WIDTH-1:0] dq);
    bit ok;
    req_x0 = x0; req_len = len; req_v = v; req_q = q; req_dv = dv; req_dq = dq;
    span_go = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (!span_go) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_eq("accept_timeout", 1'b0, 1'b1);
      span_go = 1'b0;
    end
  endtask

  task automatic wait_pix(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (pix_seen >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("pix_timeout", 32'(pix_seen), 32'(target));
  endtask

  task automatic check_idle(input string tag);
    #1;
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_span_ready"}, span_ready, 1'b1);
  endtask

  int base_iss;
  int base_pix;

  initial begin
    rst_n = 1'b0;
    req_x0 = '0; req_len = '0; req_v = '0; req_q = '0; req_dv = '0; req_dq = '0;
    #2;
    check_eq("rst_span_ready", span_ready, 1'b1);
    check_eq("rst_ip_in_valid", ip_in_valid, 1'b0);
    check_eq("rst_ip_out_ready", ip_out_ready, 1'b0);
    check_eq("rst_pix_valid", pix_valid, 1'b0);
    check_eq("rst_pix_last", pix_last, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_init_v", ip_init_v, 32'h0);
    check_eq("rst_pix_x", pix_x, 12'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Nominal span.
    base_pix = pix_seen;
    send_span(12'd10, 12'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0);
    #1;
    check_eq("nom_busy_t1", busy, 1'b1);
    check_eq("nom_in_valid_t1", ip_in_valid, 1'b1);
    wait_pix(base_pix + 3);
    check_idle("nom_end");

    // Zero-length span.
    @(posedge clk);
    saw_in_valid = 1'b0;
    send_span(12'd20, 12'd0, 32'h1, 32'h1, 32'h1, 32'h1);
    check_idle("zero");
    repeat (4) @(posedge clk);
    check_eq("zero_no_issue", saw_in_valid, 1'b0);
    check_eq("zero_busy_later", busy, 1'b0);

    // Credit limit with withheld results.
    ret_allow = 0;
    base_iss = issued;
    base_pix = pix_seen;
    send_span(12'd100, 12'd8, 32'h0000_0100, 32'h0002_0000, 32'h0000_0010, 32'hFFFF_FF00);
    repeat (10) @(posedge clk);
    check_eq("credit_issued4", 32'(issued - base_iss), 32'd4);
    #1 check_eq("credit_valid_low", ip_in_valid, 1'b0);
    ret_allow = 1;
    repeat (6) @(posedge clk);
    check_eq("credit_issued5", 32'(issued - base_iss), 32'd5);
    #1 check_eq("credit_valid_low2", ip_in_valid, 1'b0);
    ret_allow = BIG;
    wait_pix(base_pix + 8);
    check_idle("credit_end");

    // Downstream backpressure with a jittery interpolator input.
    in_rdy_rand = 1'b1;
    base_pix = pix_seen;
    send_span(12'd200, 12'd10, 32'h1234_5678, 32'h4000_0000, 32'hFFFF_0000, 32'h0000_0100);
    wait_pix(base_pix + 2);
    pix_stall = 1'b1;
    repeat (10) @(posedge clk);
    pix_stall = 1'b0;
    wait_pix(base_pix + 10);
    in_rdy_rand = 1'b0;
    check_idle("bp_end");

    // x wraps at 2^XW.
    base_pix = pix_seen;
    send_span(12'd4094, 12'd4, 32'h0, 32'h0, 32'h0000_0001, 32'h0);
    wait_pix(base_pix + 4);
    check_idle("wrap_end");

    // Reset in the middle of a span.
    base_iss = issued;
    send_span(12'h300, 12'd5, 32'h0, 32'h0, 32'h0000_0002, 32'h0);
    for (int i = 0; i < 50; i++) begin
      if (issued - base_iss >= 2) break;
      @(posedge clk);
    end
    check_eq("mid_rst_issued", 32'(issued - base_iss), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_span_ready", span_ready, 1'b1);
    check_eq("mid_rst_in_valid", ip_in_valid, 1'b0);
    check_eq("mid_rst_pix_valid", pix_valid, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_init_v", ip_init_v, 32'h0);
    check_eq("mid_rst_pix_x", pix_x, 12'h0);
    // The interpolator shares rst_n: nothing in flight survives.
    pend_v.delete(); pend_t.delete();
    exp_iv.delete(); exp_iq.delete(); exp_dv.delete(); exp_dq.delete();
    exp_x.delete(); exp_pv.delete(); exp_last.delete();
    stalled_prev = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    base_pix = pix_seen;
    send_span(12'd0, 12'd2, 32'h0000_1000, 32'h0, 32'h0000_1000, 32'h0);
    wait_pix(base_pix + 2);
    check_idle("post_rst_end");
    repeat (5) @(posedge clk);
    check_eq("post_rst_pix_count", 32'(pix_seen - base_pix), 32'd2);
    check_eq("sb_empty", 32'(exp_x.size()), 32'd0);
    check_eq("iss_empty", 32'(exp_iv.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
